mw_writeback_stage: RTL

- Memory/writeback stage of the 3-stage RISC-V core; consumer side of the M/W control decode.
- Captures the X-stage instruction into the X→MW pipeline register and re-decodes opcode/funct3/csr locally.
- Drives the regfile write port: data, rd, write enable.
- Extracts and extends load data from the dcache response and owns the tohost CSR.

---
 rtl/mw_writeback_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mw_writeback_stage.sv
// Memory/writeback stage: X->MW register, load extraction, regfile write port, tohost CSR.
// Optional retired-instruction counter port instret enabled by defining MW_INSTRET_EN.
module mw_writeback_stage #(
    parameter logic [11:0] TOHOST_ADDR = 12'h51E,
    parameter logic [31:0] PC_RESET    = 32'h0000_2000,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        x_valid,
    input  logic [31:0] x_inst,
    input  logic [31:0] x_pc,
    input  logic [31:0] x_alu,
    input  logic [31:0] x_rs1,
    input  logic [31:0] dcache_dout,
    output logic [31:0] mw_inst,
    output logic        mw_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_rwe,
    output logic [31:0] csr_tohost
`ifdef MW_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic [31:0] mw_pc;
    logic [31:0] mw_alu;
    logic [31:0] mw_rs1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mw_valid <= 1'b0;
            mw_inst  <= NOP_INST;
            mw_pc    <= PC_RESET;
            mw_alu   <= 32'd0;
            mw_rs1   <= 32'd0;
        end else if (!stall) begin
            mw_valid <= x_valid;
            mw_inst  <= x_valid ? x_inst : NOP_INST;
            mw_pc    <= x_pc;
            mw_alu   <= x_alu;
            mw_rs1   <= x_rs1;
        end
    end

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [1:0]  wb_sel;
    logic        rwe;

    assign opcode   = mw_inst[6:0];
    assign funct3   = mw_inst[14:12];
    assign csr_addr = mw_inst[31:20];
    assign wb_rd    = mw_inst[11:7];

    always_comb begin
        wb_sel = SEL_ALU;
        rwe    = 1'b0;
        case (opcode)
            7'b0000011: begin wb_sel = SEL_LOAD; rwe = 1'b1; end
            7'b0010011,
            7'b0110011,
            7'b0110111,
            7'b0010111: begin wb_sel = SEL_ALU; rwe = 1'b1; end
            7'b1101111,
            7'b1100111: begin wb_sel = SEL_PC4; rwe = 1'b1; end
            default:    begin wb_sel = SEL_ALU; rwe = 1'b0; end
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        case (mw_alu[1:0])
            2'd0:    ld_byte = dcache_dout[7:0];
            2'd1:    ld_byte = dcache_dout[15:8];
            2'd2:    ld_byte = dcache_dout[23:16];
            default: ld_byte = dcache_dout[31:24];
        endcase
        ld_half = mw_alu[1] ? dcache_dout[31:16] : dcache_dout[15:0];
        case (funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            3'b010:  ld_data = dcache_dout;
            default: ld_data = 32'd0;
        endcase
    end

    always_comb begin
        case (wb_sel)
            SEL_LOAD: wb_data = ld_data;
            SEL_PC4:  wb_data = mw_pc + 32'd4;
            default:  wb_data = mw_alu;
        endcase
    end

    // Stalled cycles must not write so a held instruction retires exactly once.
    assign wb_rwe = rwe & mw_valid & (wb_rd != 5'd0) & ~stall;

    logic csr_hit;
    assign csr_hit = mw_valid & ~stall & (opcode == 7'b1110011)
                   & (csr_addr == TOHOST_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_tohost <= 32'd0;
        end else if (csr_hit) begin
            if (funct3 == 3'b001)
                csr_tohost <= mw_rs1;
            else if (funct3 == 3'b101)
                csr_tohost <= {27'd0, mw_inst[19:15]};
        end
    end

`ifdef MW_INSTRET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instret <= 32'd0;
        else if (mw_valid && !stall)
            instret <= instret + 32'd1;
    end
`endif

endmodule
